// File: rtl/ldpc_iter_ctrl.sv
`default_nettype none
// ============================================================================
// ldpc_iter_ctrl : LDPC decoder iteration sequencer (load, CN, VN, check, done)
// Revision 1.0
// ============================================================================
module ldpc_iter_ctrl #(
   parameter int N_COL    = 24,
   parameter int MAX_ITER = 10,
   parameter int CN_LAT   = 3,
   parameter int VN_LAT   = 3
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       start_valid,
   output logic       start_ready,
   input  logic       abort,
   input  logic       syndrome_ok,
   output logic       load_en,
   output logic [4:0] load_addr,
   output logic       cn_en,
   output logic       vn_en,
   output logic       busy,
   output logic [3:0] iter_cnt,
   output logic       dec_valid,
   input  logic       dec_ready,
   output logic       dec_success,
   output logic [3:0] dec_iter
);

   localparam int c_LEN_A   = (N_COL > CN_LAT) ? N_COL : CN_LAT;
   localparam int c_MAX_LEN = (c_LEN_A > VN_LAT) ? c_LEN_A : VN_LAT;
   localparam int c_CNT_W   = (c_MAX_LEN > 1) ? $clog2(c_MAX_LEN) : 1;

   localparam logic [c_CNT_W-1:0] c_LOAD_LAST = c_CNT_W'(N_COL - 1);
   localparam logic [c_CNT_W-1:0] c_CN_LAST   = c_CNT_W'(CN_LAT - 1);
   localparam logic [c_CNT_W-1:0] c_VN_LAST   = c_CNT_W'(VN_LAT - 1);
   localparam logic [3:0]         c_MAX_ITER  = 4'(MAX_ITER);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_CN      = 3'd2,
      S_CN_WAIT = 3'd3,
      S_VN      = 3'd4,
      S_VN_WAIT = 3'd5,
      S_CHECK   = 3'd6,
      S_DONE    = 3'd7
   } state_t;

   state_t             r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic [3:0]         w_next_iter;
   logic               w_cnt_last;

   assign w_next_iter = iter_cnt + 4'd1;
   assign w_cnt_last  = (r_cnt == '0);

   // Shared down-counter: loaded with (length-1) on entry to each timed state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         start_ready <= 1'b1;
         busy        <= 1'b0;
         load_en     <= 1'b0;
         load_addr   <= 5'd0;
         cn_en       <= 1'b0;
         vn_en       <= 1'b0;
         iter_cnt    <= 4'd0;
         dec_valid   <= 1'b0;
         dec_success <= 1'b0;
         dec_iter    <= 4'd0;
      end else if (abort && (r_state != S_IDLE)) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         start_ready <= 1'b1;
         busy        <= 1'b0;
         load_en     <= 1'b0;
         load_addr   <= 5'd0;
         cn_en       <= 1'b0;
         vn_en       <= 1'b0;
         dec_valid   <= 1'b0;
         dec_success <= 1'b0;
         dec_iter    <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_valid) begin
                  r_state     <= S_LOAD;
                  r_cnt       <= c_LOAD_LAST;
                  start_ready <= 1'b0;
                  busy        <= 1'b1;
                  load_en     <= 1'b1;
                  load_addr   <= 5'd0;
                  iter_cnt    <= 4'd0;
                  dec_success <= 1'b0;
                  dec_iter    <= 4'd0;
               end
            end
            S_LOAD: begin
               if (w_cnt_last) begin
                  r_state   <= S_CN;
                  load_en   <= 1'b0;
                  load_addr <= 5'd0;
                  cn_en     <= 1'b1;
               end else begin
                  r_cnt     <= r_cnt - 1'b1;
                  load_addr <= load_addr + 5'd1;
               end
            end
            S_CN: begin
               r_state <= S_CN_WAIT;
               r_cnt   <= c_CN_LAST;
               cn_en   <= 1'b0;
            end
            S_CN_WAIT: begin
               if (w_cnt_last) begin
                  r_state <= S_VN;
                  vn_en   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_VN: begin
               r_state <= S_VN_WAIT;
               r_cnt   <= c_VN_LAST;
               vn_en   <= 1'b0;
            end
            S_VN_WAIT: begin
               if (w_cnt_last) begin
                  r_state <= S_CHECK;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_CHECK: begin
               iter_cnt <= w_next_iter;
               // A satisfied syndrome wins even on the final allowed iteration.
               if (syndrome_ok) begin
                  r_state     <= S_DONE;
                  dec_valid   <= 1'b1;
                  dec_success <= 1'b1;
                  dec_iter    <= w_next_iter;
               end else if (w_next_iter == c_MAX_ITER) begin
                  r_state     <= S_DONE;
                  dec_valid   <= 1'b1;
                  dec_success <= 1'b0;
                  dec_iter    <= w_next_iter;
               end else begin
                  r_state <= S_CN;
                  cn_en   <= 1'b1;
               end
            end
            S_DONE: begin
               if (dec_ready) begin
                  r_state     <= S_IDLE;
                  dec_valid   <= 1'b0;
                  busy        <= 1'b0;
                  start_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               start_ready <= 1'b1;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ldpc_iter_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ldpc_iter_ctrl : directed bench for ldpc_iter_ctrl (default parameters)
// Revision 1.0
// ============================================================================
module tb_ldpc_iter_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_valid = 1'b0;
   logic       start_ready;
   logic       abort = 1'b0;
   logic       syndrome_ok = 1'b0;
   logic       load_en;
   logic [4:0] load_addr;
   logic       cn_en;
   logic       vn_en;
   logic       busy;
   logic [3:0] iter_cnt;
   logic       dec_valid;
   logic       dec_ready = 1'b0;
   logic       dec_success;
   logic [3:0] dec_iter;

   int total = 0;
   int bad   = 0;
   int n_cn;
   int n_vn;

   ldpc_iter_ctrl #(.N_COL(24), .MAX_ITER(10), .CN_LAT(3), .VN_LAT(3)) dut (
      .clk(clk), .rst(rst),
      .start_valid(start_valid), .start_ready(start_ready),
      .abort(abort), .syndrome_ok(syndrome_ok),
      .load_en(load_en), .load_addr(load_addr),
      .cn_en(cn_en), .vn_en(vn_en), .busy(busy), .iter_cnt(iter_cnt),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_success(dec_success), .dec_iter(dec_iter)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_start_ready"}, start_ready, 1);
      chk({tag, "_busy"},        busy,        0);
      chk({tag, "_load_en"},     load_en,     0);
      chk({tag, "_load_addr"},   load_addr,   0);
      chk({tag, "_cn_en"},       cn_en,       0);
      chk({tag, "_vn_en"},       vn_en,       0);
      chk({tag, "_iter_cnt"},    iter_cnt,    0);
      chk({tag, "_dec_valid"},   dec_valid,   0);
      chk({tag, "_dec_success"}, dec_success, 0);
      chk({tag, "_dec_iter"},    dec_iter,    0);
   endtask

   initial begin
      // Reset
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk_reset("rst0");

      // First-iteration success, syndrome_ok held high
      syndrome_ok = 1'b1;
      start_valid = 1'b1;
      step();
      start_valid = 1'b0;
      for (int c = 1; c <= 34; c++) begin
         chk("s1_load_en", load_en, (c <= 24));
         if (c <= 24) chk("s1_addr", load_addr, c - 1);
         chk("s1_cn_en", cn_en, (c == 25));
         chk("s1_vn_en", vn_en, (c == 29));
         chk("s1_dec_valid", dec_valid, (c == 34));
         chk("s1_busy", busy, 1);
         if (c < 34) step();
      end
      chk("s1_success", dec_success, 1);
      chk("s1_dec_iter", dec_iter, 1);
      chk("s1_iter_cnt", iter_cnt, 1);
      // start_valid during the dec handshake must not start a decode
      dec_ready = 1'b1;
      start_valid = 1'b1;
      step();
      dec_ready = 1'b0;
      start_valid = 1'b0;
      chk("s1_hs_valid", dec_valid, 0);
      chk("s1_hs_ready", start_ready, 1);
      chk("s1_hs_load", load_en, 0);
      chk("s1_hs_busy", busy, 0);
      syndrome_ok = 1'b0;

      // Exhaust MAX_ITER with syndrome_ok low
      n_cn = 0;
      n_vn = 0;
      start_valid = 1'b1;
      step();
      start_valid = 1'b0;
      for (int c = 1; c <= 115; c++) begin
         if (cn_en) n_cn++;
         if (vn_en) n_vn++;
         if (c == 34) chk("s2_iter1", iter_cnt, 1);
         if (c == 114) chk("s2_valid114", dec_valid, 0);
         if (c < 115) step();
      end
      chk("s2_valid115", dec_valid, 1);
      chk("s2_success", dec_success, 0);
      chk("s2_dec_iter", dec_iter, 10);
      chk("s2_n_cn", n_cn, 10);
      chk("s2_n_vn", n_vn, 10);

      // DONE held with dec_ready low; start_valid ignored
      start_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         step();
         chk("s2_hold_valid", dec_valid, 1);
         chk("s2_hold_succ", dec_success, 0);
         chk("s2_hold_iter", dec_iter, 10);
         chk("s2_hold_sready", start_ready, 0);
         chk("s2_hold_load", load_en, 0);
      end
      start_valid = 1'b0;
      dec_ready = 1'b1;
      step();
      dec_ready = 1'b0;
      chk("s2_idle_busy", busy, 0);
      chk("s2_idle_sready", start_ready, 1);
      chk("s2_idle_valid", dec_valid, 0);

      // Syndrome pulse in VN_WAIT (cycle 40) ignored, in CHECK of iter 3 (51) taken
      start_valid = 1'b1;
      step();
      start_valid = 1'b0;
      for (int c = 1; c <= 52; c++) begin
         chk("s3_dec_valid", dec_valid, (c == 52));
         syndrome_ok = (c == 40) || (c == 51);
         if (c < 52) step();
      end
      syndrome_ok = 1'b0;
      chk("s3_success", dec_success, 1);
      chk("s3_dec_iter", dec_iter, 3);
      dec_ready = 1'b1;
      step();
      dec_ready = 1'b0;
      chk("s3_idle", start_ready, 1);

      // Abort at load_addr 10
      start_valid = 1'b1;
      step();
      start_valid = 1'b0;
      for (int c = 1; c < 11; c++) step();
      chk("s4_addr10", load_addr, 10);
      chk("s4_load_on", load_en, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("s4_ab_load", load_en, 0);
      chk("s4_ab_busy", busy, 0);
      chk("s4_ab_sready", start_ready, 1);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("s4_no_load", load_en, 0);
         chk("s4_no_valid", dec_valid, 0);
      end
      // Abort in IDLE is ignored, so this start is accepted
      abort = 1'b1;
      start_valid = 1'b1;
      step();
      abort = 1'b0;
      start_valid = 1'b0;
      chk("s4_restart_load", load_en, 1);
      chk("s4_restart_addr", load_addr, 0);
      chk("s4_restart_iter", iter_cnt, 0);

      // Reset with abort during VN_WAIT of iteration 5 (cycle 67)
      for (int c = 1; c < 67; c++) step();
      chk("s5_iter4", iter_cnt, 4);
      rst = 1'b1;
      abort = 1'b1;
      step();
      rst = 1'b0;
      abort = 1'b0;
      chk_reset("s5_rst");

      // Abort after one iteration, restart clears iter_cnt
      start_valid = 1'b1;
      step();
      start_valid = 1'b0;
      for (int c = 1; c < 40; c++) step();
      chk("s6_iter1", iter_cnt, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("s6_ab_busy", busy, 0);
      chk("s6_ab_valid", dec_valid, 0);
      start_valid = 1'b1;
      step();
      start_valid = 1'b0;
      chk("s6_iter0", iter_cnt, 0);
      chk("s6_addr0", load_addr, 0);
      chk("s6_load", load_en, 1);

      // Reset mid-LOAD
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_reset("s7_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
